// File: rtl/activation_result_writer.sv
// Result-stream sink: stores accepted activation rows into BRAM at base + k*stride
// and pulses done_write once the programmed number of rows has been written.
module activation_result_writer #(
  parameter int MAT_MUL_SIZE = 4,
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 10,
  parameter int CWIDTH       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_write,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [AWIDTH-1:0]              addr_stride,
  input  logic [CWIDTH-1:0]              num_rows,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic                           bram_we,
  output logic                           busy,
  output logic                           done_write,
  output logic [CWIDTH-1:0]              rows_written,
  output logic                           unexpected_data
);

  localparam int RW = MAT_MUL_SIZE * DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [AWIDTH-1:0] stride_q, stride_d;
  logic [CWIDTH-1:0] target_q, target_d;
  logic [CWIDTH-1:0] rows_q, rows_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              unexp_q, unexp_d;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    target_d   = target_q;
    rows_d     = rows_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unexp_d    = unexp_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_data_available) unexp_d = 1'b1;
        // An accepted start clears the flag even if a stray beat arrives with it.
        if (start_write) begin
          cur_addr_d = base_addr;
          stride_d   = addr_stride;
          target_d   = num_rows;
          rows_d     = '0;
          unexp_d    = 1'b0;
          if (num_rows == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_ACTIVE;
            busy_d  = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (in_data_available) begin
          we_d       = 1'b1;
          addr_d     = cur_addr_q;
          wdata_d    = inp_data;
          cur_addr_d = cur_addr_q + stride_q;
          rows_d     = rows_q + 1'b1;
          if (rows_d == target_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (in_data_available) unexp_d = 1'b1;
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      stride_q   <= '0;
      target_q   <= '0;
      rows_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      target_q   <= target_d;
      rows_q     <= rows_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      unexp_q    <= unexp_d;
    end
  end

  assign bram_addr       = addr_q;
  assign bram_wdata      = wdata_q;
  assign bram_we         = we_q;
  assign busy            = busy_q;
  assign done_write      = done_q;
  assign rows_written    = rows_q;
  assign unexpected_data = unexp_q;

endmodule

// File: tb/tb_activation_result_writer.sv
// Bench for activation_result_writer: directed literal scenarios plus randomized
// traffic checked every cycle against a job-level behavioural model.
module tb_activation_result_writer;
  localparam int AW = 10;
  localparam int CW = 8;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_write = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] addr_stride = '0;
  logic [CW-1:0] num_rows = '0;
  logic          in_data_available = 1'b0;
  logic [RW-1:0] inp_data = '0;
  logic [AW-1:0] bram_addr;
  logic [RW-1:0] bram_wdata;
  logic          bram_we;
  logic          busy;
  logic          done_write;
  logic [CW-1:0] rows_written;
  logic          unexpected_data;

  activation_result_writer #(
    .MAT_MUL_SIZE(4), .DWIDTH(8), .AWIDTH(AW), .CWIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start_write(start_write),
    .base_addr(base_addr), .addr_stride(addr_stride), .num_rows(num_rows),
    .in_data_available(in_data_available), .inp_data(inp_data),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .busy(busy), .done_write(done_write), .rows_written(rows_written),
    .unexpected_data(unexpected_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: 0 = idle, 1 = collecting rows, 2 = completion cycle.
  int            m_phase, m_k, m_n;
  logic [AW-1:0] m_base, m_stride;
  logic [AW-1:0] e_addr;
  logic [RW-1:0] e_wdata;
  logic          e_we, e_busy, e_done, e_unexp;
  logic [CW-1:0] e_rows;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_n = 0; m_base = '0; m_stride = '0;
    e_addr = '0; e_wdata = '0; e_we = 0; e_busy = 0; e_done = 0; e_unexp = 0; e_rows = '0;
  endtask

  task automatic model_step();
    e_we = 0;
    e_done = 0;
    case (m_phase)
      0: begin
        if (start_write) begin
          m_base = base_addr; m_stride = addr_stride; m_n = int'(num_rows); m_k = 0;
          e_unexp = 0;
          m_phase = (m_n == 0) ? 2 : 1;
          e_done = (m_n == 0);
        end else if (in_data_available) begin
          e_unexp = 1;
        end
      end
      1: begin
        if (in_data_available) begin
          e_addr  = AW'((int'(m_base) + m_k * int'(m_stride)) % (1 << AW));
          e_wdata = inp_data;
          e_we    = 1;
          m_k++;
          if (m_k == m_n) begin
            m_phase = 2;
            e_done  = 1;
          end
        end
      end
      default: begin
        if (in_data_available) e_unexp = 1;
        m_phase = 0;
      end
    endcase
    e_busy = (m_phase == 1);
    e_rows = CW'(m_k);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model.bram_we", bram_we, e_we);
        chk("model.bram_addr", bram_addr, e_addr);
        chk("model.bram_wdata", bram_wdata, e_wdata);
        chk("model.busy", busy, e_busy);
        chk("model.done_write", done_write, e_done);
        chk("model.rows_written", rows_written, e_rows);
        chk("model.unexpected_data", unexpected_data, e_unexp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n);
    start_write = 1; base_addr = b; addr_stride = s; num_rows = n;
    step();
    start_write = 0;
  endtask

  task automatic beat(input logic [RW-1:0] d);
    in_data_available = 1; inp_data = d;
    step();
    in_data_available = 0;
  endtask

  task automatic chk_write(input string nm, input logic [AW-1:0] a, input logic [RW-1:0] d);
    chk({nm, ".we"}, bram_we, 1'b1);
    chk({nm, ".addr"}, bram_addr, a);
    chk({nm, ".data"}, bram_wdata, d);
  endtask

  logic [RW-1:0] t1_data [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  logic [AW-1:0] t2_addr [3] = '{10'h3FE, 10'h001, 10'h004};

  initial begin
    #2 reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    chk_en = 1;
    chk("reset.we", bram_we, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.rows", rows_written, 8'd0);
    chk("reset.addr", bram_addr, 10'd0);

    // 1: contiguous rows
    start_job(10'h010, 10'd1, 8'd4);
    chk("t1.busy", busy, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      beat(t1_data[i]);
      chk_write("t1.wr", AW'(10'h010 + i), t1_data[i]);
      chk("t1.done", done_write, (i == 3) ? 1'b1 : 1'b0);
    end
    step();
    chk("t1.rows", rows_written, 8'd4);
    chk("t1.busy_after", busy, 1'b0);
    chk("t1.done_after", done_write, 1'b0);

    // 2: gapped strobes with address wrap
    start_job(10'h3FE, 10'd3, 8'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      beat(32'hA0 + i);
      chk_write("t2.wr", t2_addr[i], 32'hA0 + i);
      chk("t2.done", done_write, (i == 2) ? 1'b1 : 1'b0);
      if (i < 2) begin
        step();
        chk("t2.gap_we", bram_we, 1'b0);
      end
    end

    // 3: zero-row job
    step();
    start_job(10'h123, 10'd5, 8'd0);
    chk("t3.done", done_write, 1'b1);
    chk("t3.we", bram_we, 1'b0);
    chk("t3.busy", busy, 1'b0);
    step();
    chk("t3.done_after", done_write, 1'b0);

    // 4: stray strobes and flag clearing
    beat(32'hDEAD);
    chk("t4.unexp_set", unexpected_data, 1'b1);
    chk("t4.no_we", bram_we, 1'b0);
    in_data_available = 1;
    start_job(10'h050, 10'd1, 8'd1);
    in_data_available = 0;
    chk("t4.unexp_clr", unexpected_data, 1'b0);
    chk("t4.no_we2", bram_we, 1'b0);
    beat(32'h55);
    chk_write("t4.wr", 10'h050, 32'h55);
    chk("t4.done", done_write, 1'b1);
    beat(32'h66);
    chk("t4.unexp_after_done", unexpected_data, 1'b1);

    // 5: asynchronous reset mid-job, then clean restart
    start_job(10'h100, 10'd1, 8'd5);
    beat(32'h1);
    beat(32'h2);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("t5.rst_we", bram_we, 1'b0);
    chk("t5.rst_addr", bram_addr, 10'd0);
    chk("t5.rst_data", bram_wdata, 32'd0);
    chk("t5.rst_busy", busy, 1'b0);
    chk("t5.rst_rows", rows_written, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    start_job(10'h020, 10'd1, 8'd2);
    beat(32'hC1);
    chk_write("t5.wr0", 10'h020, 32'hC1);
    beat(32'hC2);
    chk_write("t5.wr1", 10'h021, 32'hC2);
    chk("t5.done", done_write, 1'b1);
    step();

    // 6: start during an active job is ignored
    start_job(10'h040, 10'd2, 8'd3);
    start_write = 1; base_addr = 10'h300; addr_stride = 10'd7; num_rows = 8'd9;
    for (int unsigned i = 0; i < 3; i++) begin
      beat(32'hE0 + i);
      chk_write("t6.wr", AW'(10'h040 + 2 * i), 32'hE0 + i);
    end
    start_write = 0;
    step();

    // randomized traffic, checked by the model every cycle
    for (int unsigned c = 0; c < 3000; c++) begin
      start_write       = ($urandom_range(0, 7) == 0);
      base_addr         = AW'($urandom);
      addr_stride       = AW'($urandom);
      num_rows          = CW'($urandom_range(0, 6));
      in_data_available = ($urandom_range(0, 2) != 0);
      inp_data          = $urandom;
      step();
    end
    start_write = 0;
    in_data_available = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/activation_result_writer.md
Name: activation_result_writer

Overview:
- Sink end of the activation output stream: accepts row vectors qualified by a data-available strobe and writes them into an on-chip result BRAM.
- Writes use a programmable base address and row stride.
- Signals completion once a programmed number of rows has been stored.
- Sits between the activation stage and the output/result buffer.

Parameters:
MAT_MUL_SIZE, 4, elements per row vector
DWIDTH, 8, bits per element
AWIDTH, 10, BRAM address width
CWIDTH, 8, width of row-count field

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start_write  input  1  start request; sampled in IDLE only
base_addr  input  AWIDTH  first write address; latched on accepted start
addr_stride  input  AWIDTH  address increment per row; latched on accepted start
num_rows  input  CWIDTH  rows to store; latched on accepted start
in_data_available  input  1  row-valid strobe from activation stage
inp_data  input  MAT_MUL_SIZE*DWIDTH  row vector; element 0 in LSBs
bram_addr  output  AWIDTH  write address (registered)
bram_wdata  output  MAT_MUL_SIZE*DWIDTH  write data (registered)
bram_we  output  1  write enable (registered)
busy  output  1  high while in ACTIVE
done_write  output  1  one-cycle completion pulse
rows_written  output  CWIDTH  rows stored in current/last job
unexpected_data  output  1  sticky: strobe seen while not ACTIVE

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - bram_addr=0, bram_wdata=0, bram_we=0, busy=0, done_write=0, rows_written=0, unexpected_data=0.
  - Internal address, stride and target registers also =0.
- Reset mid-job: immediate return to IDLE with all outputs as above. Rows already written stay in BRAM; there is no resume.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - start_write=1 with num_rows!=0: latch base_addr, addr_stride, num_rows; clear rows_written and unexpected_data; go to ACTIVE next cycle.
  - start_write=1 with num_rows=0: latch the same fields, clear the same registers, go directly to DONE (no writes).
  - in_data_available=1 while in IDLE is dropped and sets unexpected_data. Exception: in the same cycle as an accepted start, the clear has priority, so the flag is 0 and the beat is dropped.
- ACTIVE:
  - busy=1. Each cycle with in_data_available=1 accepts one row.
  - Registered write at t+1 (1-cycle latency): bram_we=1, bram_addr=cur_addr, bram_wdata=inp_data from cycle t.
  - Update: cur_addr += stride, modulo 2^AWIDTH (wrap, no error); rows_written += 1.
  - When the accepted row is number num_rows, go to DONE at t+1.
  - Cycles without the strobe give bram_we=0 next cycle; bram_addr and bram_wdata hold their last values.
  - start_write is ignored in ACTIVE.
  - Back-to-back strobes on every cycle are supported at full rate. There is no backpressure; the source must not exceed num_rows beats.
- DONE:
  - done_write=1 for exactly one cycle; busy=0; return to IDLE next cycle.
  - The final bram_we pulse and done_write are asserted in the same cycle.
  - A strobe seen in DONE is dropped and sets unexpected_data.
  - start_write in DONE is ignored.
- rows_written holds its value after DONE until the next accepted start.
- unexpected_data is cleared only by reset or by an accepted start.
- Throughput: num_rows rows complete in num_rows+2 cycles minimum from start (start cycle, num_rows accept cycles, DONE).

Test Plan:
1. base=0x010, stride=1, num_rows=4, strobe on 4 consecutive cycles with data 0x01020304..0x0D0E0F10 -> bram_we high 4 cycles at addr 0x010..0x013 with matching data; done_write one pulse coincident with 4th write; rows_written=4; busy=0 after.
2. base=0x3FE, stride=3, num_rows=3 with gapped strobes (1 idle cycle between) -> writes at 0x3FE, 0x001, 0x004 (wrap); bram_we low in gap cycles; done_write after 3rd accepted row.
3. num_rows=0 with start -> DONE next cycle, done_write pulse, no bram_we, busy never high.
4. Strobe in IDLE -> unexpected_data=1 and no write. Next start with a simultaneous strobe -> flag clears, no write. Strobe one cycle after done -> flag=1.
5. Assert reset asynchronously (between clock edges) after 2 of 5 rows -> all outputs 0 immediately. Restart base=0x020, num_rows=2 -> clean writes at 0x020, 0x021 (stride 1).
6. start_write toggled during ACTIVE with different base -> ignored; addresses continue from original base/stride.
